// File: rtl/axil_bridge_pkg.sv
// Shared encodings for the AXI to AXI-Lite bridge: FSM states and AXI response codes.
package axil_bridge_pkg;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_ISSUE = 2'd1,
    WR_RESP  = 2'd2,
    WR_ACK   = 2'd3
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_ISSUE = 2'd1,
    RD_DATA  = 2'd2,
    RD_ACK   = 2'd3
  } rd_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_rd_path.sv
// Read half of the bridge: captures one AR, forwards it to the AXI-Lite side and
// returns the downstream data and response upstream.
module axil_rd_path
  import axil_bridge_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int AXIL_ADDR_W = 4,
  parameter int DATA_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_W-1:0]      axi_araddr,
  input  logic                   axi_arvalid,
  output logic                   axi_arready,
  output logic [DATA_W-1:0]      axi_rdata,
  output logic [1:0]             axi_rresp,
  output logic                   axi_rvalid,
  input  logic                   axi_rready,
  output logic [AXIL_ADDR_W-1:0] axil_araddr,
  output logic                   axil_arvalid,
  input  logic                   axil_arready,
  input  logic [DATA_W-1:0]      axil_rdata,
  input  logic [1:0]             axil_rresp,
  input  logic                   axil_rvalid,
  output logic                   axil_rready
);

  rd_state_e         rd_state;
  logic [ADDR_W-1:0] araddr_q;
  logic              unused_araddr_hi;

  assign axi_arready = (rd_state == RD_IDLE);

  // Upper address bits are dropped, never decoded.
  assign axil_araddr      = araddr_q[AXIL_ADDR_W-1:0];
  assign unused_araddr_hi = ^araddr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state     <= RD_IDLE;
      araddr_q     <= '0;
      axil_arvalid <= 1'b0;
      axil_rready  <= 1'b0;
      axi_rdata    <= '0;
      axi_rresp    <= AXI_RESP_OKAY;
      axi_rvalid   <= 1'b0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (axi_arvalid) begin
            araddr_q     <= axi_araddr;
            axil_arvalid <= 1'b1;
            rd_state     <= RD_ISSUE;
          end
        end
        RD_ISSUE: begin
          if (axil_arready) begin
            axil_arvalid <= 1'b0;
            axil_rready  <= 1'b1;
            rd_state     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (axil_rvalid) begin
            axi_rdata   <= axil_rdata;
            axi_rresp   <= axil_rresp;
            axil_rready <= 1'b0;
            axi_rvalid  <= 1'b1;
            rd_state    <= RD_ACK;
          end
        end
        RD_ACK: begin
          if (axi_rready) begin
            axi_rvalid <= 1'b0;
            rd_state   <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/axil_bridge.sv
// AXI to AXI-Lite bridge: one outstanding write and one outstanding read, each
// running its own FSM; address truncated to AXIL_ADDR_W, strobes and responses passed through.
module axil_bridge
  import axil_bridge_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int AXIL_ADDR_W = 4,
  parameter int DATA_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_W-1:0]      axi_awaddr,
  input  logic                   axi_awvalid,
  output logic                   axi_awready,
  input  logic [DATA_W-1:0]      axi_wdata,
  input  logic [DATA_W/8-1:0]    axi_wstrb,
  input  logic                   axi_wvalid,
  output logic                   axi_wready,
  output logic [1:0]             axi_bresp,
  output logic                   axi_bvalid,
  input  logic                   axi_bready,
  input  logic [ADDR_W-1:0]      axi_araddr,
  input  logic                   axi_arvalid,
  output logic                   axi_arready,
  output logic [DATA_W-1:0]      axi_rdata,
  output logic [1:0]             axi_rresp,
  output logic                   axi_rvalid,
  input  logic                   axi_rready,
  output logic [AXIL_ADDR_W-1:0] axil_awaddr,
  output logic                   axil_awvalid,
  input  logic                   axil_awready,
  output logic [DATA_W-1:0]      axil_wdata,
  output logic [DATA_W/8-1:0]    axil_wstrb,
  output logic                   axil_wvalid,
  input  logic                   axil_wready,
  input  logic [1:0]             axil_bresp,
  input  logic                   axil_bvalid,
  output logic                   axil_bready,
  output logic [AXIL_ADDR_W-1:0] axil_araddr,
  output logic                   axil_arvalid,
  input  logic                   axil_arready,
  input  logic [DATA_W-1:0]      axil_rdata,
  input  logic [1:0]             axil_rresp,
  input  logic                   axil_rvalid,
  output logic                   axil_rready
);

  // Handshakes: a transfer happens on the rising edge where valid && ready. A valid,
  // once raised, holds with stable payload until its transfer; readies may toggle freely.
  // Every valid here is a register, and readies decode only from FSM state and flags.

  wr_state_e           wr_state;
  logic                aw_got, w_got, aw_done, w_done;
  logic [ADDR_W-1:0]   awaddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [1:0]          bresp_q;
  logic                up_aw_hs, up_w_hs, dn_aw_hs, dn_w_hs;
  logic                aw_got_nx, w_got_nx, aw_done_nx, w_done_nx;
  logic                unused_awaddr_hi;

  assign axi_awready = (wr_state == WR_IDLE) && !aw_got;
  assign axi_wready  = (wr_state == WR_IDLE) && !w_got;

  assign up_aw_hs   = axi_awvalid && axi_awready;
  assign up_w_hs    = axi_wvalid && axi_wready;
  assign dn_aw_hs   = axil_awvalid && axil_awready;
  assign dn_w_hs    = axil_wvalid && axil_wready;

  // A handshake in the deciding cycle counts toward the transition.
  assign aw_got_nx  = aw_got || up_aw_hs;
  assign w_got_nx   = w_got || up_w_hs;
  assign aw_done_nx = aw_done || dn_aw_hs;
  assign w_done_nx  = w_done || dn_w_hs;

  assign axil_awaddr      = awaddr_q[AXIL_ADDR_W-1:0];
  assign axil_wdata       = wdata_q;
  assign axil_wstrb       = wstrb_q;
  assign axi_bresp        = bresp_q;
  assign unused_awaddr_hi = ^awaddr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state     <= WR_IDLE;
      aw_got       <= 1'b0;
      w_got        <= 1'b0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      bresp_q      <= AXI_RESP_OKAY;
      axil_awvalid <= 1'b0;
      axil_wvalid  <= 1'b0;
      axil_bready  <= 1'b0;
      axi_bvalid   <= 1'b0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (up_aw_hs) begin
            awaddr_q <= axi_awaddr;
            aw_got   <= 1'b1;
          end
          if (up_w_hs) begin
            wdata_q <= axi_wdata;
            wstrb_q <= axi_wstrb;
            w_got   <= 1'b1;
          end
          if (aw_got_nx && w_got_nx) begin
            axil_awvalid <= 1'b1;
            axil_wvalid  <= 1'b1;
            wr_state     <= WR_ISSUE;
          end
        end
        WR_ISSUE: begin
          if (dn_aw_hs) begin
            axil_awvalid <= 1'b0;
            aw_done      <= 1'b1;
          end
          if (dn_w_hs) begin
            axil_wvalid <= 1'b0;
            w_done      <= 1'b1;
          end
          if (aw_done_nx && w_done_nx) begin
            axil_bready <= 1'b1;
            wr_state    <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (axil_bvalid) begin
            bresp_q     <= axil_bresp;
            axil_bready <= 1'b0;
            axi_bvalid  <= 1'b1;
            wr_state    <= WR_ACK;
          end
        end
        WR_ACK: begin
          if (axi_bready) begin
            axi_bvalid <= 1'b0;
            aw_got     <= 1'b0;
            w_got      <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            wr_state   <= WR_IDLE;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  axil_rd_path #(
    .ADDR_W      (ADDR_W),
    .AXIL_ADDR_W (AXIL_ADDR_W),
    .DATA_W      (DATA_W)
  ) u_rd_path (
    .clk          (clk),
    .rst_n        (rst_n),
    .axi_araddr   (axi_araddr),
    .axi_arvalid  (axi_arvalid),
    .axi_arready  (axi_arready),
    .axi_rdata    (axi_rdata),
    .axi_rresp    (axi_rresp),
    .axi_rvalid   (axi_rvalid),
    .axi_rready   (axi_rready),
    .axil_araddr  (axil_araddr),
    .axil_arvalid (axil_arvalid),
    .axil_arready (axil_arready),
    .axil_rdata   (axil_rdata),
    .axil_rresp   (axil_rresp),
    .axil_rvalid  (axil_rvalid),
    .axil_rready  (axil_rready)
  );

endmodule

// File: tb/tb_axil_bridge.sv
// Directed bench for axil_bridge: upstream master driven from one initial block,
// a responding AXI-Lite slave with configurable stalls, and queue-based scoreboards.
module tb_axil_bridge;

  localparam int ADDR_W      = 32;
  localparam int AXIL_ADDR_W = 4;
  localparam int DATA_W      = 32;
  localparam int STRB_W      = DATA_W / 8;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [ADDR_W-1:0]      axi_awaddr, axi_araddr;
  logic                   axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic [DATA_W-1:0]      axi_wdata, axi_rdata;
  logic [STRB_W-1:0]      axi_wstrb;
  logic [1:0]             axi_bresp, axi_rresp;
  logic                   axi_bvalid, axi_bready, axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic [AXIL_ADDR_W-1:0] axil_awaddr, axil_araddr;
  logic                   axil_awvalid, axil_awready, axil_wvalid, axil_wready;
  logic [DATA_W-1:0]      axil_wdata, axil_rdata;
  logic [STRB_W-1:0]      axil_wstrb;
  logic [1:0]             axil_bresp, axil_rresp;
  logic                   axil_bvalid, axil_bready, axil_arvalid, axil_arready, axil_rvalid, axil_rready;

  int n_chk = 0;
  int n_fail = 0;

  logic [AXIL_ADDR_W-1:0]   exp_aw_q[$];
  logic [AXIL_ADDR_W-1:0]   exp_ar_q[$];
  logic [STRB_W+DATA_W-1:0] exp_w_q[$];
  logic [1:0]               exp_b_q[$];
  logic [DATA_W+1:0]        exp_r_q[$];

  int aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0;
  int exp_aw_n = 0, exp_w_n = 0, exp_ar_n = 0;

  // Slave behaviour knobs.
  int                s_aw_dly = 0, s_w_dly = 0, s_b_dly = 0, s_ar_dly = 0, s_r_dly = 0;
  bit                s_rand = 1'b0;
  logic [1:0]        s_bresp = 2'b00, s_rresp = 2'b00;
  logic [DATA_W-1:0] s_rdata = '0;

  axil_bridge #(
    .ADDR_W      (ADDR_W),
    .AXIL_ADDR_W (AXIL_ADDR_W),
    .DATA_W      (DATA_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .axi_awaddr   (axi_awaddr),
    .axi_awvalid  (axi_awvalid),
    .axi_awready  (axi_awready),
    .axi_wdata    (axi_wdata),
    .axi_wstrb    (axi_wstrb),
    .axi_wvalid   (axi_wvalid),
    .axi_wready   (axi_wready),
    .axi_bresp    (axi_bresp),
    .axi_bvalid   (axi_bvalid),
    .axi_bready   (axi_bready),
    .axi_araddr   (axi_araddr),
    .axi_arvalid  (axi_arvalid),
    .axi_arready  (axi_arready),
    .axi_rdata    (axi_rdata),
    .axi_rresp    (axi_rresp),
    .axi_rvalid   (axi_rvalid),
    .axi_rready   (axi_rready),
    .axil_awaddr  (axil_awaddr),
    .axil_awvalid (axil_awvalid),
    .axil_awready (axil_awready),
    .axil_wdata   (axil_wdata),
    .axil_wstrb   (axil_wstrb),
    .axil_wvalid  (axil_wvalid),
    .axil_wready  (axil_wready),
    .axil_bresp   (axil_bresp),
    .axil_bvalid  (axil_bvalid),
    .axil_bready  (axil_bready),
    .axil_araddr  (axil_araddr),
    .axil_arvalid (axil_arvalid),
    .axil_arready (axil_arready),
    .axil_rdata   (axil_rdata),
    .axil_rresp   (axil_rresp),
    .axil_rvalid  (axil_rvalid),
    .axil_rready  (axil_rready)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int d);
    return s_rand ? int'($urandom_range(0, 3)) : d;
  endfunction

  // ---------------- AXI-Lite slave responder ----------------
  initial begin : slave
    int  aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    int  aw_lim, w_lim, b_lim, ar_lim, r_lim;
    bit  p_aw, p_w, p_b, p_ar, p_r;
    bit  aw_seen, w_seen, ar_seen;
    logic [AXIL_ADDR_W-1:0]   p_awaddr, p_araddr;
    logic [STRB_W+DATA_W-1:0] p_wpay;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    aw_lim = 0; w_lim = 0; b_lim = 0; ar_lim = 0; r_lim = 0;
    p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
    aw_seen = 0; w_seen = 0; ar_seen = 0;
    p_awaddr = '0; p_araddr = '0; p_wpay = '0;
    axil_awready = 0; axil_wready = 0; axil_bvalid = 0; axil_bresp = 0;
    axil_arready = 0; axil_rvalid = 0; axil_rdata = '0; axil_rresp = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        axil_awready = 0; axil_wready = 0; axil_bvalid = 0;
        axil_arready = 0; axil_rvalid = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
        aw_seen = 0; w_seen = 0; ar_seen = 0;
      end else begin
        // Retire the transfers that completed on the edge just passed.
        if (p_aw) begin
          aw_hs_n++; axil_awready = 0; aw_seen = 1; aw_cnt = 0;
          check("aw_expected", exp_aw_q.size() != 0, 1'b1);
          if (exp_aw_q.size() != 0) check("axil_awaddr", p_awaddr, exp_aw_q.pop_front());
        end
        if (p_w) begin
          w_hs_n++; axil_wready = 0; w_seen = 1; w_cnt = 0;
          check("w_expected", exp_w_q.size() != 0, 1'b1);
          if (exp_w_q.size() != 0) check("axil_wstrb_wdata", p_wpay, exp_w_q.pop_front());
        end
        if (p_b) axil_bvalid = 0;
        if (p_ar) begin
          ar_hs_n++; axil_arready = 0; ar_seen = 1; ar_cnt = 0;
          check("ar_expected", exp_ar_q.size() != 0, 1'b1);
          if (exp_ar_q.size() != 0) check("axil_araddr", p_araddr, exp_ar_q.pop_front());
        end
        if (p_r) axil_rvalid = 0;

        if (axil_awvalid && !axil_awready) begin
          if (aw_cnt == 0) aw_lim = pick(s_aw_dly);
          if (aw_cnt >= aw_lim) axil_awready = 1; else aw_cnt++;
        end
        if (axil_wvalid && !axil_wready) begin
          if (w_cnt == 0) w_lim = pick(s_w_dly);
          if (w_cnt >= w_lim) axil_wready = 1; else w_cnt++;
        end
        if (aw_seen && w_seen && !axil_bvalid) begin
          if (b_cnt == 0) b_lim = pick(s_b_dly);
          if (b_cnt >= b_lim) begin
            axil_bvalid = 1; axil_bresp = s_bresp; aw_seen = 0; w_seen = 0; b_cnt = 0;
          end else b_cnt++;
        end
        if (axil_arvalid && !axil_arready) begin
          if (ar_cnt == 0) ar_lim = pick(s_ar_dly);
          if (ar_cnt >= ar_lim) axil_arready = 1; else ar_cnt++;
        end
        if (ar_seen && !axil_rvalid) begin
          if (r_cnt == 0) r_lim = pick(s_r_dly);
          if (r_cnt >= r_lim) begin
            axil_rvalid = 1; axil_rdata = s_rdata; axil_rresp = s_rresp; ar_seen = 0; r_cnt = 0;
          end else r_cnt++;
        end

        p_aw = axil_awvalid && axil_awready; p_awaddr = axil_awaddr;
        p_w  = axil_wvalid && axil_wready;   p_wpay = {axil_wstrb, axil_wdata};
        p_b  = axil_bvalid && axil_bready;
        p_ar = axil_arvalid && axil_arready; p_araddr = axil_araddr;
        p_r  = axil_rvalid && axil_rready;
      end
    end
  end

  // ---------------- upstream driver tasks ----------------
  task automatic drive_up(input bit do_aw, input bit do_w, input bit do_ar,
                          input logic [ADDR_W-1:0] aw_a, input logic [DATA_W-1:0] wd,
                          input logic [STRB_W-1:0] ws, input logic [ADDR_W-1:0] ar_a);
    bit aw_hs, w_hs, ar_hs;
    int cyc;
    cyc = 0;
    @(negedge clk);
    if (do_aw) begin
      axi_awaddr = aw_a; axi_awvalid = 1;
      exp_aw_q.push_back(aw_a[AXIL_ADDR_W-1:0]); exp_aw_n++;
    end
    if (do_w) begin
      axi_wdata = wd; axi_wstrb = ws; axi_wvalid = 1;
      exp_w_q.push_back({ws, wd}); exp_w_n++;
      exp_b_q.push_back(s_bresp);
    end
    if (do_ar) begin
      axi_araddr = ar_a; axi_arvalid = 1;
      exp_ar_q.push_back(ar_a[AXIL_ADDR_W-1:0]); exp_ar_n++;
      exp_r_q.push_back({s_rdata, s_rresp});
    end
    while ((axi_awvalid || axi_wvalid || axi_arvalid) && cyc < 100) begin
      aw_hs = axi_awvalid && axi_awready;
      w_hs  = axi_wvalid && axi_wready;
      ar_hs = axi_arvalid && axi_arready;
      @(negedge clk);
      cyc++;
      if (aw_hs) axi_awvalid = 0;
      if (w_hs)  axi_wvalid = 0;
      if (ar_hs) axi_arvalid = 0;
    end
    check("up_handshakes", {axi_awvalid, axi_wvalid, axi_arvalid}, 3'b000);
    axi_awvalid = 0; axi_wvalid = 0; axi_arvalid = 0;
  endtask

  // Accepts B and/or R after holding each ready low for 'hold' valid cycles.
  task automatic collect(input bit want_b, input bit want_r, input int hold);
    bit b_done, r_done;
    int hb, hr, cyc;
    b_done = !want_b; r_done = !want_r; hb = 0; hr = 0; cyc = 0;
    while (!(b_done && r_done) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (!b_done) begin
        if (axi_bready) begin
          axi_bready = 0; b_done = 1;
          check("b_drop", axi_bvalid, 1'b0);
        end else if (axi_bvalid || hb > 0) begin
          check("bvalid_hold", axi_bvalid, 1'b1);
          check("b_expected", exp_b_q.size() != 0, 1'b1);
          if (exp_b_q.size() != 0) begin
            check("axi_bresp", axi_bresp, exp_b_q[0]);
            if (hb >= hold) begin axi_bready = 1; void'(exp_b_q.pop_front()); end
          end
          hb++;
        end
      end
      if (!r_done) begin
        if (axi_rready) begin
          axi_rready = 0; r_done = 1;
          check("r_drop", axi_rvalid, 1'b0);
        end else if (axi_rvalid || hr > 0) begin
          check("rvalid_hold", axi_rvalid, 1'b1);
          check("r_expected", exp_r_q.size() != 0, 1'b1);
          if (exp_r_q.size() != 0) begin
            check("axi_rdata_rresp", {axi_rdata, axi_rresp}, exp_r_q[0]);
            if (hr >= hold) begin axi_rready = 1; void'(exp_r_q.pop_front()); end
          end
          hr++;
        end
      end
    end
    check("collect_done", {b_done, r_done}, 2'b11);
    axi_bready = 0; axi_rready = 0;
  endtask

  task automatic check_idle(input string tag);
    check(tag, {axi_awready, axi_wready, axi_arready}, 3'b111);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    axi_awaddr = '0; axi_awvalid = 0; axi_wdata = '0; axi_wstrb = '0; axi_wvalid = 0;
    axi_bready = 0; axi_araddr = '0; axi_arvalid = 0; axi_rready = 0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    check("rst_valids", {axil_awvalid, axil_wvalid, axil_bready, axil_arvalid,
                         axil_rready, axi_bvalid, axi_rvalid}, 7'b0);
    rst_n = 1;
    @(negedge clk);
    check_idle("rst_readies");

    // Write with AW and W together, zero-wait slave: cycle-accurate latency.
    drive_up(1, 1, 0, 32'h0000_1234, 32'hDEAD_BEEF, 4'hF, '0);
    check("t1_c1_dn_valids", {axil_awvalid, axil_wvalid}, 2'b11);
    check("t1_awaddr", axil_awaddr, 4'h4);
    check("t1_wdata", axil_wdata, 32'hDEAD_BEEF);
    check("t1_up_busy", {axi_awready, axi_wready}, 2'b00);
    @(negedge clk);
    check("t1_c2_bready", axil_bready, 1'b1);
    check("t1_c2_dn_valids", {axil_awvalid, axil_wvalid}, 2'b00);
    @(negedge clk);
    check("t1_c3_bvalid", axi_bvalid, 1'b1);
    check("t1_c3_bresp", axi_bresp, 2'b00);
    collect(1, 0, 0);
    check_idle("t1_idle");

    // Read minimum latency.
    s_rdata = 32'hCAFE_0001; s_rresp = 2'b00;
    drive_up(0, 0, 1, '0, '0, '0, 32'h0000_1234);
    check("rd_c1_arvalid", axil_arvalid, 1'b1);
    check("rd_c1_araddr", axil_araddr, 4'h4);
    check("rd_c1_arready", axi_arready, 1'b0);
    @(negedge clk);
    check("rd_c2_rready", axil_rready, 1'b1);
    @(negedge clk);
    check("rd_c3_rvalid", axi_rvalid, 1'b1);
    check("rd_c3_rdata", axi_rdata, 32'hCAFE_0001);
    collect(0, 1, 0);

    // W ahead of AW; downstream AW stalled 2 cycles.
    s_aw_dly = 2;
    drive_up(0, 1, 0, '0, 32'h0BAD_F00D, 4'h6, '0);
    check("t2_w_captured", {axi_awready, axi_wready, axil_wvalid}, 3'b100);
    @(negedge clk);
    drive_up(1, 0, 0, 32'hFFFF_FFF8, '0, '0, '0);
    check("t2_c1_dn_valids", {axil_awvalid, axil_wvalid}, 2'b11);
    @(negedge clk);
    check("t2_c2_w_dropped", {axil_awvalid, axil_wvalid}, 2'b10);
    @(negedge clk);
    check("t2_c3_aw_held", axil_awvalid, 1'b1);
    collect(1, 0, 0);
    check("t2_aw_count", aw_hs_n, exp_aw_n);
    check("t2_w_count", w_hs_n, exp_w_n);
    s_aw_dly = 0;

    // Error responses held against stalled upstream readies.
    s_bresp = 2'b10; s_rresp = 2'b11; s_rdata = 32'h5A5A_0003;
    drive_up(1, 1, 1, 32'h0000_0004, 32'h1111_2222, 4'h3, 32'h0000_0008);
    collect(1, 1, 4);
    @(negedge clk);
    check_idle("t3_idle");

    // Concurrent read of 0x8 and write to 0xC under random stalls.
    s_rand = 1;
    for (int i = 0; i < 4; i++) begin
      s_bresp = 2'($urandom_range(0, 3));
      s_rresp = 2'($urandom_range(0, 3));
      s_rdata = $urandom;
      drive_up(1, 1, 1, 32'h0000_100C, $urandom, 4'($urandom_range(0, 15)), 32'h0000_2008);
      collect(1, 1, $urandom_range(0, 2));
    end
    s_rand = 0;
    s_bresp = 2'b00; s_rresp = 2'b00;

    // Reset while parked in WR_RESP and RD_DATA.
    s_b_dly = 20; s_r_dly = 20; s_rdata = 32'h0000_00EE;
    drive_up(1, 1, 1, 32'h0000_000C, 32'h7777_8888, 4'hF, 32'h0000_0008);
    repeat (2) @(negedge clk);
    check("t5_parked", {axil_bready, axil_rready}, 2'b11);
    rst_n = 0;
    #1;
    check("t5_rst_valids", {axil_awvalid, axil_wvalid, axil_bready, axil_arvalid,
                            axil_rready, axi_bvalid, axi_rvalid}, 7'b0);
    exp_b_q.delete(); exp_r_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    s_b_dly = 0; s_r_dly = 0;
    @(negedge clk);
    check_idle("t5_readies");
    drive_up(1, 1, 0, 32'h0000_0ABC, 32'h1234_5678, 4'h9, '0);
    collect(1, 0, 0);
    check_idle("t5_idle");

    check("end_queues_empty", exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size()
                              + exp_b_q.size() + exp_r_q.size(), 0);
    check("end_hs_counts", {aw_hs_n[15:0], w_hs_n[15:0], ar_hs_n[15:0]},
          {exp_aw_n[15:0], exp_w_n[15:0], exp_ar_n[15:0]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
